// File: rtl/if_id_fetch_stage_pkg.sv
// if_id_fetch_stage_pkg: shared fetch-stage constants, FSM states and next-PC select encoding.
package if_id_fetch_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {BOOT, RUN} fetch_state_t;
  typedef enum logic [2:0] {SEQ, BR, J, JR, HOLD} npc_sel_t;
endpackage

// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if: redirect/hazard controls, instruction-memory bus and IF/ID outputs.
interface if_id_fetch_stage_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic stall, IF_flush, jump, bne_taken, jr;
  logic [XLEN-1:0] jump_target, branch_target, jr_target;
  logic [31:0] imem_rdata, IF_ID_instr;
  logic [XLEN-1:0] imem_addr, IF_ID_pc4;
  logic imem_req, IF_ID_valid;
  logic [CNT_W-1:0] flush_count;
  modport master (
    input  stall, IF_flush, jump, jump_target, bne_taken, branch_target, jr, jr_target, imem_rdata,
    output imem_addr, imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid, flush_count
  );
  modport slave (
    output stall, IF_flush, jump, jump_target, bne_taken, branch_target, jr, jr_target, imem_rdata,
    input  imem_addr, imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid, flush_count
  );
endinterface

// File: rtl/if_id_fetch_stage_next_pc_sel.sv
// if_id_fetch_stage_next_pc_sel: priority next-PC mux and effective-flush decode.
module if_id_fetch_stage_next_pc_sel
  import if_id_fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            IF_flush,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            bne_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc4,
  output logic            flush_eff
);
  npc_sel_t sel;
  always_comb begin
    pc4 = pc + XLEN'(4);
    sel = jr ? JR : jump ? J : bne_taken ? BR : stall ? HOLD : SEQ;
    case (sel)
      JR:      next_pc = jr_target;
      J:       next_pc = jump_target;
      BR:      next_pc = branch_target;
      HOLD:    next_pc = pc;
      default: next_pc = pc4;
    endcase
    flush_eff = IF_flush | jump | bne_taken | jr;
  end
endmodule

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC register, BOOT/RUN fetch FSM, IF/ID register and saturating flush counter.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input logic             clk,
  input logic             reset,
  if_id_fetch_stage_if.master bus
);
  fetch_state_t state, state_nxt;
  logic [XLEN-1:0] pc, next_pc, pc4;
  logic flush_eff, run;

  if_id_fetch_stage_next_pc_sel #(.XLEN(XLEN)) u_sel (
    .pc(pc),
    .stall(bus.stall),
    .IF_flush(bus.IF_flush),
    .jump(bus.jump),
    .jump_target(bus.jump_target),
    .bne_taken(bus.bne_taken),
    .branch_target(bus.branch_target),
    .jr(bus.jr),
    .jr_target(bus.jr_target),
    .next_pc(next_pc),
    .pc4(pc4),
    .flush_eff(flush_eff)
  );

  always_comb begin
    state_nxt = (state == BOOT) ? RUN : state;
    run = (state == RUN);
  end

  assign bus.imem_addr = pc;
  assign bus.imem_req  = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= BOOT;
      pc              <= RESET_PC;
      bus.IF_ID_instr <= NOP_INSTR;
      bus.IF_ID_pc4   <= '0;
      bus.IF_ID_valid <= 1'b0;
      bus.flush_count <= '0;
    end else begin
      state <= state_nxt;
      if (run) begin
        pc <= next_pc;
        if (flush_eff) begin
          bus.IF_ID_instr <= NOP_INSTR;
          bus.IF_ID_pc4   <= '0;
          bus.IF_ID_valid <= 1'b0;
        end else if (!bus.stall) begin
          bus.IF_ID_instr <= bus.imem_rdata;
          bus.IF_ID_pc4   <= pc4;
          bus.IF_ID_valid <= 1'b1;
        end
        // Counter saturates at all-ones so long flush storms never wrap to small values.
        if (flush_eff && bus.flush_count != '1) bus.flush_count <= bus.flush_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_if_id_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        req;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];

  if_id_fetch_stage_if #(.XLEN(32), .CNT_W(16)) bus ();

  if_id_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word depends on address, 0 -> 32'h2002_0005.
  assign bus.imem_rdata = bus.imem_addr + 32'h2002_0005;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.imem_addr !== e.addr || bus.imem_req !== e.req || bus.IF_ID_instr !== e.instr ||
          bus.IF_ID_pc4 !== e.pc4 || bus.IF_ID_valid !== e.valid || bus.flush_count !== e.fc) begin
        errors++;
        $display("FAIL %s: got addr=%h req=%b instr=%h pc4=%h valid=%b fc=%h, expected addr=%h req=%b instr=%h pc4=%h valid=%b fc=%h",
                 e.name, bus.imem_addr, bus.imem_req, bus.IF_ID_instr, bus.IF_ID_pc4, bus.IF_ID_valid,
                 bus.flush_count, e.addr, e.req, e.instr, e.pc4, e.valid, e.fc);
      end
    end
  end

  task automatic drive(input logic rst, input logic st, input logic fl, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic r, input logic [31:0] rt);
    reset = rst; bus.stall = st; bus.IF_flush = fl;
    bus.jump = j; bus.jump_target = jt; bus.bne_taken = b; bus.branch_target = bt;
    bus.jr = r; bus.jr_target = rt;
  endtask

  task automatic cyc(input string name, input logic chk, input logic [31:0] addr, input logic req,
                     input logic [31:0] instr, input logic [31:0] pc4, input logic valid, input logic [15:0] fc);
    exp_t e;
    @(posedge clk);
    if (chk) begin
      e.name = name; e.addr = addr; e.req = req; e.instr = instr; e.pc4 = pc4; e.valid = valid; e.fc = fc;
      q.push_back(e);
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 32'h0, 0, 32'h0, 32'h0, 0, 16'd0);
    drive(0, 1, 1, 1, 32'h80, 1, 32'h90, 1, 32'hA0);
    cyc("boot_ignores", 1, 32'h0, 1, 32'h0, 32'h0, 0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("first_fetch", 1, 32'h4, 1, 32'h2002_0005, 32'h4, 1, 16'd0);
    cyc("seq_8", 1, 32'h8, 1, 32'h2002_0009, 32'h8, 1, 16'd0);
    drive(0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    cyc("jump_40", 1, 32'h40, 1, 32'h0, 32'h0, 0, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("seq_44", 1, 32'h44, 1, 32'h2002_0045, 32'h44, 1, 16'd1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("stall_1", 1, 32'h44, 1, 32'h2002_0045, 32'h44, 1, 16'd1);
    cyc("stall_2", 1, 32'h44, 1, 32'h2002_0045, 32'h44, 1, 16'd1);
    drive(0, 1, 0, 1, 32'h200, 0, 0, 1, 32'h100);
    cyc("jr_over_jump_stall", 1, 32'h100, 1, 32'h0, 32'h0, 0, 16'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("seq_104", 1, 32'h104, 1, 32'h2002_0105, 32'h104, 1, 16'd2);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("if_flush_only", 1, 32'h108, 1, 32'h0, 32'h0, 0, 16'd3);
    drive(0, 1, 0, 0, 0, 1, 32'h60, 0, 0);
    cyc("bne_over_stall", 1, 32'h60, 1, 32'h0, 32'h0, 0, 16'd4);
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc("jump_top", 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h0, 0, 16'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("pc_wrap", 1, 32'h0, 1, 32'h2002_0001, 32'h0, 1, 16'd5);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("flush_over_stall", 1, 32'h0, 1, 32'h0, 32'h0, 0, 16'd6);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65538; i++) cyc("flush_run", 0, 0, 0, 0, 0, 0, 0);
    cyc("flush_saturate", 1, 32'h0004_000C, 1, 32'h0, 32'h0, 0, 16'hFFFF);
    cyc("flush_hold_max", 1, 32'h0004_0010, 1, 32'h0, 32'h0, 0, 16'hFFFF);
    drive(1, 0, 0, 0, 0, 1, 32'h80, 0, 0);
    cyc("reset_over_bne", 1, 32'h0, 0, 32'h0, 32'h0, 0, 16'd0);
    drive(0, 0, 0, 0, 0, 1, 32'h80, 0, 0);
    cyc("boot_after_reset", 1, 32'h0, 1, 32'h0, 32'h0, 0, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("refetch", 1, 32'h4, 1, 32'h2002_0005, 32'h4, 1, 16'd0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID-stage control path and the flush/NOP block.
- Owns the program counter and next-PC selection (sequential, bne, jump, jr).
- Drives the instruction-memory address and holds the fetched instruction and PC+4 for ID.
- Applies IF_flush (turns the fetched slot into a bubble) and stall (freezes PC and IF/ID). Counts flushes for performance debug.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating flush counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  load-use hazard hold from the hazard unit.
- IF_flush  input  1  discard the instruction currently being fetched.
- jump  input  1  unconditional jump resolved in ID.
- jump_target  input  XLEN  jump destination.
- bne_taken  input  1  taken branch resolved in ID.
- branch_target  input  XLEN  branch destination.
- jr  input  1  jump-register resolved in ID.
- jr_target  input  XLEN  register destination.
- imem_rdata  input  32  instruction word. Instruction memory reads combinationally at imem_addr.
- imem_addr  output  XLEN  current PC.
- imem_req  output  1  fetch enable; 0 during BOOT.
- IF_ID_instr  output  32  instruction word presented to ID.
- IF_ID_pc4  output  XLEN  PC+4 of that instruction.
- IF_ID_valid  output  1  IF/ID slot holds a real instruction.
- flush_count  output  CNT_W  number of cycles in which a flush was applied.

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, the following load, and reset overrides every other input:
  - pc=RESET_PC
  - IF_ID_instr=32'h0 (NOP)
  - IF_ID_pc4=0
  - IF_ID_valid=0
  - flush_count=0
  - state=BOOT
- Reset mid-operation discards any in-flight redirect or stall.
- FSM states:
  - BOOT: imem_req=0; pc holds; IF/ID holds its bubble. Next state is RUN unconditionally, so the first fetch happens one cycle after reset deasserts.
  - RUN: imem_req=1; normal operation.
- imem_addr=pc at all times. Latency: an instruction fetched in cycle N appears on IF_ID_* in cycle N+1.
- Effective flush: flush_eff = IF_flush | jump | bne_taken | jr. Any redirect implies a flush even if IF_flush is low.
- Next-PC priority, applied in RUN only:
  1. jr → jr_target
  2. jump → jump_target
  3. bne_taken → branch_target
  4. stall → hold pc
  5. otherwise pc+4
- Redirect beats stall: on simultaneous stall and redirect, the PC loads the target.
- IF/ID update in RUN, by priority:
  - flush_eff=1: instr=0, pc4=0, valid=0. Flush wins over stall.
  - stall=1: hold all IF/ID fields.
  - otherwise: instr=imem_rdata, pc4=pc+4, valid=1.
- IF_flush alone (no select line): bubble inserted and the PC advances to pc+4.
- PC arithmetic: modulo 2^XLEN, so pc+4 from 32'hFFFF_FFFC wraps to 0.
- Targets: loaded unmodified; no alignment check.
- flush_count:
  - increments by 1 in each RUN cycle with flush_eff=1.
  - saturates at all-ones, with no wrap.
  - does not count in BOOT.
- In BOOT, redirect, stall and flush inputs are ignored.
- All outputs are registered except imem_addr (=pc register) and imem_req (decoded from state).

Decomposition:
- Shared cpu package holds:
  - NOP_INSTR = 32'h0
  - RESET_PC default
  - fetch FSM state typedef {BOOT, RUN}
  - next-PC select encoding {SEQ, BR, J, JR, HOLD}
- One natural sub-module, next_pc_sel: purely combinational priority mux producing next pc and flush_eff. Keep the registers in the top module.

Test Plan:
- Reset release, imem returns 32'h2002_0005 at addr 0:
  - cycle 1 is BOOT with imem_req=0 and imem_addr=0.
  - cycle 2 fetches.
  - cycle 3 shows IF_ID_instr=32'h2002_0005, pc4=4, valid=1.
- Sequential run of 4 fetches from 0 → imem_addr sequence 0, 4, 8, 12; IF_ID_pc4 follows one cycle later.
- jump=1 with jump_target=32'h40 at pc=8 → next imem_addr=32'h40; IF/ID gets a bubble (instr=0, valid=0); flush_count increments 0→1.
- stall=1 for 2 cycles at pc=12 → imem_addr holds 12 and IF_ID holds its contents. Then jr=1, jump=1 and stall=1 together with jr_target=32'h100 and jump_target=32'h200 → pc=32'h100 and a bubble.
- pc forced near top via jump_target=32'hFFFF_FFFC, no redirect → next pc=0, IF_ID_pc4=0. Also: flush asserted for 2^CNT_W+3 cycles → flush_count holds 16'hFFFF.
- reset asserted in the same cycle as bne_taken=1 with branch_target=32'h80 → pc=RESET_PC, valid=0, flush_count=0, state BOOT; branch ignored.
